simple_stim_driver: RTL
=======================

// Module: simple_stim_driver
// PURPOSE
//   On-chip initiator for the 2-input/1-output `simple` netlist interface.
//   Drives inp1/inp2 from an LFSR, samples the netlist's out after a fixed latency,
//   and compacts the responses into a 16-bit MISR signature.
//   Sits beside the netlist under test as its self-test driver, giving a pass/fail
//   result for netlist-enhancer regressions.
// PARAMETERS
//   NUM_PAT     16     number of patterns applied per run (0..65535)
//   PIPE_LAT    1      cycles from driving inp1/inp2 to a valid out (0..7; 1 = one flop in path)
//   LFSR_SEED   8'h01  LFSR value loaded on start (must be non-zero)
//   EXP_SIG     16'h0  expected signature; pass = (sig == EXP_SIG)
// PORTS
//   iccad_clk    in   1   single clock, rising edge
//   iccad_rst_n  in   1   asynchronous active-low reset
//   start        in   1   1-cycle request to begin a run; sampled only in IDLE
//   dut_inp1     out  1   drives netlist inp1 (registered)
//   dut_inp2     out  1   drives netlist inp2 (registered)
//   dut_out      in   1   netlist out
//   busy         out  1   high from cycle after accepted start until done
//   done         out  1   1-cycle pulse: signature final
//   sig          out  16  MISR signature, held from done until next accepted start
//   pass         out  1   valid with done, held like sig
// BEHAVIOUR
//   Reset (async, any state): FSM=IDLE; all outputs 0; LFSR=LFSR_SEED; MISR=0; counters 0.
//   FSM IDLE -> RUN (start=1) -> DRAIN (last pattern driven) -> DONE (last sample) -> IDLE.
//   - IDLE:  start=1 at cycle T: load LFSR_SEED, clear MISR, pat_cnt=0, clear sig/pass.
//   - RUN:   cycles T+1..T+NUM_PAT; dut_inp1=lfsr[0], dut_inp2=lfsr[1]; LFSR advances each cycle.
//   - DRAIN: holds last pattern for PIPE_LAT cycles.
//   - DONE:  one cycle; done=1, busy=0.
//   LFSR:  next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
//   Capture: the pattern driven in cycle c is sampled from dut_out at the end of cycle c+PIPE_LAT.
//            Track it with a (PIPE_LAT+1)-deep valid shift register.
//            Exactly NUM_PAT samples are taken; the last is at the end of cycle T+NUM_PAT+PIPE_LAT.
//   MISR update per sample: m' = {m[14:0],1'b0} ^ (m[15] ? 16'h1021 : 16'h0) ^ {15'b0, dut_out}.
//   done=1 in cycle T+NUM_PAT+PIPE_LAT+1.
//   - Same cycle: sig=MISR, pass=(MISR==EXP_SIG).
//   - Both held until the next accepted start.
//   busy: 1 in cycles T+1..T+NUM_PAT+PIPE_LAT.
//   Boundaries:
//   - NUM_PAT=0: no RUN/DRAIN; done in cycle T+1; sig=0.
//   - start while busy or in DONE: ignored, no queuing.
//   - start held high: one run per IDLE visit.
//   - Reset mid-run: aborts immediately; sig/pass cleared; no done pulse.
//   - PIPE_LAT=0: DRAIN skipped; samples taken in the same cycle the pattern is driven.
//   - Counters are sized for NUM_PAT=65535 without wrap; LFSR wraps naturally (period 255).
// STRUCTURE
//   Package simple_stim_pkg: FSM state typedef (IDLE, RUN, DRAIN, DONE),
//   LFSR taps const, MISR_POLY=16'h1021, SIG_W=16.
//   Sub-module sig_misr: 16-bit MISR with clear, enable and 1-bit data in.
//   LFSR, FSM and latency tracker stay in the top module.
// TESTING
//   1 LFSR_SEED=01, start at T -> (inp1,inp2) = (1,0),(0,1),(0,0) in T+1..T+3; busy rises at T+1.
//   2 dut_out tied 0, NUM_PAT=16, PIPE_LAT=1 -> done at T+18; sig=16'h0000; pass=1 (EXP_SIG=0).
//   3 NUM_PAT=1, PIPE_LAT=1, dut_out=1 only in cycle T+2 -> done at T+3, sig=16'h0001, pass=0.
//   4 NUM_PAT=0 -> done at T+1, busy never high, sig=0; start pulsed while busy in test 2 -> no effect, done once.
//   5 iccad_rst_n low at T+5 of a 16-pattern run -> all outputs 0 at once; no done; new start runs cleanly.
//   6 Real `simple` netlist connected, PIPE_LAT=1 -> sig matches the reference-model MISR over the 16 LFSR patterns.

Source files
------------

// File: rtl/simple_stim_driver_pkg.sv
`default_nettype none
// ============================================================================
// Package : simple_stim_pkg
// Brief   : Shared types and constants for the simple-netlist stimulus driver:
//           FSM state encoding, LFSR feedback taps, MISR polynomial and width.
// Revision: 1.0 - initial release
// ============================================================================
package simple_stim_pkg;

  // Run sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Signature width and compaction polynomial
  localparam int              SIG_W     = 16;
  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

  // Feedback taps of the 8-bit pattern LFSR: bits 7, 5, 4 and 3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Pattern counter width: holds 65535 plus headroom so the compare never wraps
  localparam int CNT_W = 17;

  // One LFSR step: shift left, feedback is the XOR of the tapped bits
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/simple_stim_driver_sig_misr.sv
`default_nettype none
// ============================================================================
// Module  : sig_misr
// Brief   : 16-bit multiple-input signature register with a single-bit data
//           input. Clear has priority over enable; the register holds its value
//           when neither is asserted.
// Revision: 1.0 - initial release
// ============================================================================
module sig_misr
  import simple_stim_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             data_in,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_next;

  // Next signature: shift with polynomial feedback from the MSB, fold in data
  always_comb begin
    sig_next = sig;
    if (clear) begin
      sig_next = '0;
    end else if (enable) begin
      sig_next = {sig[SIG_W-2:0], 1'b0}
               ^ (sig[SIG_W-1] ? MISR_POLY : '0)
               ^ {{(SIG_W-1){1'b0}}, data_in};
    end
  end

  // Signature register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else begin
      sig <= sig_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/simple_stim_driver.sv
`default_nettype none
// ============================================================================
// Module  : simple_stim_driver
// Brief   : Self-test initiator for the 2-input/1-output `simple` netlist.
//           Drives inp1/inp2 from an 8-bit LFSR for NUM_PAT cycles, samples the
//           netlist output PIPE_LAT cycles after each pattern, compacts the
//           samples into a 16-bit MISR and reports the signature with a
//           pass flag against EXP_SIG.
// Revision: 1.0 - initial release
// ============================================================================
module simple_stim_driver
  import simple_stim_pkg::*;
#(
  parameter int              NUM_PAT   = 16,
  parameter int              PIPE_LAT  = 1,
  parameter logic [7:0]      LFSR_SEED = 8'h01,
  parameter logic [SIG_W-1:0] EXP_SIG  = 16'h0000
) (
  input  logic             iccad_clk,
  input  logic             iccad_rst_n,
  input  logic             start,
  output logic             dut_inp1,
  output logic             dut_inp2,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic             pass
);

  localparam logic [CNT_W-1:0] PAT_TOTAL  = CNT_W'(NUM_PAT);
  // Last value of the drain counter; meaningless (and unused) when PIPE_LAT=0
  localparam logic [2:0]       DRAIN_LAST = 3'(PIPE_LAT - 1);

  state_t           state;
  state_t           next_state;
  logic             accept;      // start seen in IDLE this cycle
  logic             drive_pat;   // RUN still has patterns to launch
  logic             issue;       // a new pattern is launched at the coming edge
  logic             enter_done;  // coming edge moves the FSM into DONE
  logic [7:0]       pat_src;     // value whose low bits form the launched pattern
  logic [7:0]       lfsr;
  logic [CNT_W-1:0] pat_cnt;     // patterns launched so far in this run
  logic [2:0]       drain_cnt;
  logic [PIPE_LAT:0] vld;        // vld[i]: the pattern driven i cycles ago is live
  logic             sample_en;
  logic [SIG_W-1:0] misr_val;
  logic [SIG_W-1:0] sig_hold;
  logic             pass_hold;

  // FSM state register
  always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
    if (!iccad_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state and control decode
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    drive_pat  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = (NUM_PAT == 0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (pat_cnt < PAT_TOTAL) begin
          drive_pat = 1'b1;
        end else begin
          next_state = (PIPE_LAT == 0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // The first pattern of a run launches on the accepting edge, from the seed
  assign issue      = drive_pat || (accept && (PAT_TOTAL != '0));
  assign pat_src    = accept ? LFSR_SEED : lfsr;
  assign enter_done = (next_state == ST_DONE) && (state != ST_DONE);

  // Pattern generator: LFSR, launch counter and registered netlist inputs
  always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
    if (!iccad_rst_n) begin
      lfsr     <= LFSR_SEED;
      pat_cnt  <= '0;
      dut_inp1 <= 1'b0;
      dut_inp2 <= 1'b0;
    end else begin
      if (issue) begin
        dut_inp1 <= pat_src[0];
        dut_inp2 <= pat_src[1];
        lfsr     <= lfsr_next(pat_src);
      end else if (accept) begin
        lfsr <= LFSR_SEED;
      end else if (enter_done) begin
        // Return the netlist inputs to a quiet level once all samples are in
        dut_inp1 <= 1'b0;
        dut_inp2 <= 1'b0;
      end

      if (accept) begin
        pat_cnt <= issue ? CNT_W'(1) : '0;
      end else if (drive_pat) begin
        pat_cnt <= pat_cnt + CNT_W'(1);
      end
    end
  end

  // Drain timer: counts cycles spent holding the last pattern
  always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
    if (!iccad_rst_n) begin
      drain_cnt <= '0;
    end else if (state == ST_DRAIN) begin
      drain_cnt <= drain_cnt + 3'd1;
    end else begin
      drain_cnt <= '0;
    end
  end

  // Latency tracker: vld[0] marks a freshly driven pattern, deeper bits age it
  generate
    if (PIPE_LAT > 0) begin : g_lat_pipe
      always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
        if (!iccad_rst_n) begin
          vld <= '0;
        end else begin
          vld <= {vld[PIPE_LAT-1:0], issue};
        end
      end
    end else begin : g_lat_none
      always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
        if (!iccad_rst_n) begin
          vld <= '0;
        end else begin
          vld <= issue;
        end
      end
    end
  endgenerate

  // The netlist output belongs to a pattern when that pattern is PIPE_LAT old
  assign sample_en = vld[PIPE_LAT];

  sig_misr u_misr (
    .clk     (iccad_clk),
    .rst_n   (iccad_rst_n),
    .clear   (accept),
    .enable  (sample_en),
    .data_in (dut_out),
    .sig     (misr_val)
  );

  // Result hold: capture the final signature in DONE, clear on a new run
  always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
    if (!iccad_rst_n) begin
      sig_hold  <= '0;
      pass_hold <= 1'b0;
    end else if (state == ST_DONE) begin
      sig_hold  <= misr_val;
      pass_hold <= (misr_val == EXP_SIG);
    end else if (accept) begin
      sig_hold  <= '0;
      pass_hold <= 1'b0;
    end
  end

  // The MISR is frozen during DONE, so it can be shown directly that cycle
  assign sig  = (state == ST_DONE) ? misr_val : sig_hold;
  assign pass = (state == ST_DONE) ? (misr_val == EXP_SIG) : pass_hold;

endmodule
`default_nettype wire
